// File: rtl/c17_resp_misr.sv
// ---------------------------------------------------------------------------
// c17_resp_misr
//
// Self-test sink for the bit-level pipelined c17 stage. A valid flag is
// issued alongside each upstream input vector and delayed LATENCY cycles so
// that it lines up with the registered c17 outputs N22/N23. While a run is
// active, every aligned response is folded into a multiple-input signature
// register (MISR). After NVEC responses the block stops and compares the
// final signature against exp_sig.
//
// Parameters:
//   LATENCY  register stages in the upstream c17 pipeline (>= 1)
//   NVEC     responses compacted per run (1..255)
//   SIG_W    MISR width (>= 4)
//   POLY     MISR feedback polynomial
//   SEED     MISR value loaded at the start of a run and on reset
//
// Ports:
//   clk        rising-edge clock shared with the c17 stage
//   rst        synchronous, active-high reset
//   start      one-cycle pulse that begins a run (accepted in IDLE and DONE)
//   in_valid   high in the cycle a vector is presented to the c17 inputs
//   N22, N23   c17 outputs, already delayed by LATENCY registers
//   exp_sig    expected final signature (stable while done=1)
//   busy       high while a run is collecting responses
//   done       high once NVEC responses have been compacted
//   pass       done and signature matches exp_sig
//   signature  current MISR contents
//   vec_cnt    responses compacted in the current run
//
// Optional build macro:
//   C17_MISR_XCHK_EN  simulation-only check that N22/N23 are not X/Z when
//                     they are about to be compacted. Synthesised logic is
//                     the same with or without it.
// ---------------------------------------------------------------------------
module c17_resp_misr #(
    parameter int               LATENCY = 2,
    parameter int               NVEC    = 16,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             N22,
    input  logic             N23,
    input  logic [SIG_W-1:0] exp_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [7:0]       vec_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] NVEC_C = 8'(NVEC);

    logic [1:0]         state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [LATENCY-1:0] vd_q, vd_d;

    logic               av;
    logic [7:0]         cnt_inc;
    logic [SIG_W-1:0]   misr_next;

    // Valid delay line: one stage per c17 pipeline register. It runs in
    // every state and is only cleared by reset, so valids issued just
    // before a start are still in flight when the run begins.
    assign vd_d[0] = in_valid;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vd
            assign vd_d[gi] = vd_q[gi-1];
        end
    endgenerate

    assign av      = vd_q[LATENCY-1];
    assign cnt_inc = cnt_q + 8'd1;

    // Shift left with polynomial feedback from the MSB, then inject the two
    // response bits into the bottom of the register.
    assign misr_next = ({sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0))
                     ^ {{(SIG_W-2){1'b0}}, N23, N22};

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sig_d   = SEED;
                    cnt_d   = 8'd0;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here: a run always
                // completes, including when start lands on the final edge.
                if (av) begin
                    sig_d = misr_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == NVEC_C) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sig_d   = SEED;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= 8'd0;
            vd_q    <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            vd_q    <= vd_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (sig_q == exp_sig);
    assign signature = sig_q;
    assign vec_cnt   = cnt_q;

`ifdef C17_MISR_XCHK_EN
    // Flags unknown responses at the moment they are folded in; the update
    // itself is not blocked, so the signature will carry the X onward.
    always @(posedge clk) begin
        if (!rst && state_q == ST_RUN && av && ($isunknown(N22) || $isunknown(N23))) begin
            $error("c17_resp_misr: X/Z on N22/N23 at time %0t, vec_cnt=%0d", $time, cnt_q);
        end
    end
`else
`endif

endmodule

// File: tb/tb_c17_resp_misr.sv
module tb_c17_resp_misr;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, n22, n23;
    logic [15:0] exp_sig;

    logic        busy1, done1, pass1;
    logic [15:0] sig1;
    logic [7:0]  cnt1;
    logic        busy2, done2, pass2;
    logic [15:0] sig2;
    logic [7:0]  cnt2;
    logic        busy16, done16, pass16;
    logic [15:0] sig16;
    logic [7:0]  cnt16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c17_resp_misr #(.LATENCY(2), .NVEC(1), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .N22(n22), .N23(n23),
        .exp_sig(exp_sig), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .vec_cnt(cnt1));

    c17_resp_misr #(.LATENCY(2), .NVEC(2), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF)) u2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .N22(n22), .N23(n23),
        .exp_sig(exp_sig), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .vec_cnt(cnt2));

    c17_resp_misr #(.LATENCY(2), .NVEC(16), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF)) u16 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .N22(n22), .N23(n23),
        .exp_sig(exp_sig), .busy(busy16), .done(done16), .pass(pass16), .signature(sig16), .vec_cnt(cnt16));

    typedef struct {
        logic        start;
        logic        iv;
        logic        n23;
        logic        n22;
        logic        busy;
        logic        done;
        logic        pass;
        logic [7:0]  cnt;
        logic [15:0] sig;
    } vec_t;

    typedef struct {
        logic [1:0]  n_a;   // {N23,N22} in the cycle ending at edge t+1
        logic [1:0]  n_b;   // {N23,N22} in the cycle ending at edge t+2
        logic [15:0] sig;
    } align_t;

    localparam int NT = 20;
    vec_t   tbl[0:NT-1];
    align_t atbl[0:3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; n22 = 1'b0; n23 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b23, input logic b22);
        logic [15:0] r;
        r = {s[14:0], 1'b0};
        if (s[15]) r = r ^ 16'h1021;
        r[1] = r[1] ^ b23;
        r[0] = r[0] ^ b22;
        return r;
    endfunction

    initial begin
        logic [15:0] model;
        int          w;

        // ---- table: start, iv, n23, n22 | busy, done, pass, cnt, sig (NVEC=2)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'hEFDF};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 16'hCF9F};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 16'hCF9F};
        // restart from DONE with in_valid on the start edge, then gaps 1,0,0,1
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'hEFDF};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'hEFDF};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'hEFDF};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 16'hCF9F};
        // aligned valids arriving in DONE are discarded
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 16'hCF9F};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 16'hCF9F};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 16'hCF9F};
        // nonzero responses, start coincident with the final update edge
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'hFFFF};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'hEFDD};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 16'hCF9A};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 16'hCF9A};

        atbl[0] = '{2'b00, 2'b11, 16'hEFDC};
        atbl[1] = '{2'b11, 2'b00, 16'hEFDF};
        atbl[2] = '{2'b00, 2'b10, 16'hEFDD};
        atbl[3] = '{2'b00, 2'b01, 16'hEFDE};

        exp_sig = 16'hCF9F;

        // ---- reset values
        do_reset();
        chk("rst_busy", {15'd0, busy2}, 16'd0);
        chk("rst_done", {15'd0, done2}, 16'd0);
        chk("rst_pass", {15'd0, pass2}, 16'd0);
        chk("rst_sig",  sig2, 16'hFFFF);
        chk("rst_cnt",  {8'd0, cnt2}, 16'd0);
        $display("reset: busy=%0b done=%0b pass=%0b sig=%h cnt=%0d", busy2, done2, pass2, sig2, cnt2);

        // ---- table-driven run on the NVEC=2 instance
        for (int i = 0; i < NT; i++) begin
            start = tbl[i].start; in_valid = tbl[i].iv; n23 = tbl[i].n23; n22 = tbl[i].n22;
            tick();
            chk($sformatf("v%0d_busy", i), {15'd0, busy2}, {15'd0, tbl[i].busy});
            chk($sformatf("v%0d_done", i), {15'd0, done2}, {15'd0, tbl[i].done});
            chk($sformatf("v%0d_pass", i), {15'd0, pass2}, {15'd0, tbl[i].pass});
            chk($sformatf("v%0d_cnt",  i), {8'd0, cnt2},  {8'd0, tbl[i].cnt});
            chk($sformatf("v%0d_sig",  i), sig2, tbl[i].sig);
            $display("vec %0d: start=%0b iv=%0b n=%0b%0b -> busy=%0b done=%0b pass=%0b cnt=%0d sig=%h",
                     i, tbl[i].start, tbl[i].iv, tbl[i].n23, tbl[i].n22, busy2, done2, pass2, cnt2, sig2);
        end
        start = 1'b0; in_valid = 1'b0; n22 = 1'b0; n23 = 1'b0;

        // pass follows exp_sig combinationally while done
        exp_sig = 16'hCF9A; #1;
        chk("pass_match", {15'd0, pass2}, 16'd1);
        exp_sig = 16'h0000; #1;
        chk("pass_mismatch", {15'd0, pass2}, 16'd0);
        $display("pass check: done=%0b pass=%0b", done2, pass2);

        // ---- alignment on the NVEC=1 instance
        for (int i = 0; i < 4; i++) begin
            do_reset();
            start = 1'b1; tick();
            start = 1'b0; in_valid = 1'b1; tick();              // edge t
            in_valid = 1'b0; {n23, n22} = atbl[i].n_a; tick();  // edge t+1
            {n23, n22} = atbl[i].n_b; tick();                   // edge t+2
            {n23, n22} = 2'b00;
            chk($sformatf("align%0d_sig", i), sig1, atbl[i].sig);
            chk($sformatf("align%0d_done", i), {15'd0, done1}, 16'd1);
            $display("align %0d: n_a=%b n_b=%b -> done=%0b sig=%h", i, atbl[i].n_a, atbl[i].n_b, done1, sig1);
        end

        // ---- abort mid-run on the NVEC=16 instance
        do_reset();
        start = 1'b1; tick();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 7; i++) tick();
        chk("abort_precnt", {8'd0, cnt16}, 16'd5);
        rst = 1'b1; in_valid = 1'b0; tick();
        chk("abort_busy", {15'd0, busy16}, 16'd0);
        chk("abort_done", {15'd0, done16}, 16'd0);
        chk("abort_cnt",  {8'd0, cnt16}, 16'd0);
        chk("abort_sig",  sig16, 16'hFFFF);
        rst = 1'b0; tick(); tick();
        chk("idle_cnt", {8'd0, cnt16}, 16'd0);
        $display("abort: busy=%0b done=%0b cnt=%0d sig=%h", busy16, done16, cnt16, sig16);

        // ---- full 16-vector run with a stray start mid-run
        model = 16'hFFFF;
        for (int i = 0; i < 16; i++) model = misr_step(model, 1'b0, 1'b0);
        exp_sig = model;
        start = 1'b1; tick();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            start = (i == 8);
            tick();
            if (i == 8) begin
                chk("runstart_cnt",  {8'd0, cnt16}, 16'd6);
                chk("runstart_busy", {15'd0, busy16}, 16'd1);
                $display("start in RUN: busy=%0b cnt=%0d", busy16, cnt16);
            end
        end
        start = 1'b0; in_valid = 1'b0;
        w = 0;
        while (w < 20 && !done16) begin
            tick();
            w++;
        end
        chk("full_done",  {15'd0, done16}, 16'd1);
        chk("full_lat",   16'(w), 16'd2);
        chk("full_cnt",   {8'd0, cnt16}, 16'd16);
        chk("full_sig",   sig16, model);
        chk("full_pass",  {15'd0, pass16}, 16'd1);
        chk("full_busy",  {15'd0, busy16}, 16'd0);
        $display("full run: done=%0b pass=%0b cnt=%0d sig=%h", done16, pass16, cnt16, sig16);
        tick(); tick();
        chk("full_hold_cnt", {8'd0, cnt16}, 16'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c17_resp_misr.md
# c17_resp_misr

Downstream response compactor for the bit-level pipelined c17 stage.
- Consumes N22/N23 from the c17 stage and realigns them with a valid flag issued alongside the upstream input vector.
- Folds NVEC aligned responses into a multiple-input signature register (MISR), then compares the signature against an expected value.
- Sits directly after the c17 pipeline as the self-test sink: pass/fail without per-vector golden checking.

## Interface
- LATENCY, 2: register stages in the upstream c17 pipeline, ≥1.
- NVEC, 16: aligned responses compacted per run, 1..255.
- SIG_W, 16: MISR width, ≥4.
- POLY, 16'h1021: MISR feedback polynomial (SIG_W bits).
- SEED, 16'hFFFF: MISR initial value.

Ports:
- clk  in  1  rising-edge clock shared with the c17 stage
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; one-cycle pulse
- in_valid  in  1  high in the cycle a vector is presented to the c17 stage inputs
- N22  in  1  c17 output
- N23  in  1  c17 output
- exp_sig  in  SIG_W  expected final signature; must be stable while done=1
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  done & (signature == exp_sig)
- signature  out  SIG_W  current MISR contents
- vec_cnt  out  8  responses compacted in the current run

## Operation
- Valid delay line vd[LATENCY-1:0]:
  - vd[0] <= in_valid; shifts every cycle in all states.
  - Aligned valid av = vd[LATENCY-1].
  - Cleared only by rst.
- States:
  - IDLE:
    - start -> RUN, signature <= SEED, vec_cnt <= 0.
  - RUN:
    - av=1 -> MISR update, vec_cnt+1.
    - Update that makes vec_cnt == NVEC -> DONE at the same edge.
    - av=0 -> hold.
    - start ignored.
  - DONE:
    - Holds signature and vec_cnt.
    - start -> RUN with signature <= SEED, vec_cnt <= 0.
    - av ignored.
- MISR update: signature <= ({signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0)) ^ {{SIG_W-2{1'b0}}, N23, N22}.
- Responses with av=1 outside RUN are discarded.
  - The delay line is not flushed on start, so in-flight valids issued just before start are counted. Upstream must not assert in_valid before start.
- pass is combinational from registered state and exp_sig. It is 0 whenever done=0.

## Timing
- Reset values: state IDLE, busy=0, done=0, pass=0, signature=SEED, vec_cnt=0, vd=0.
- rst during RUN or DONE aborts immediately to the reset values. A partial signature is lost.
- start sampled at edge k:
  - busy=1 after edge k.
  - in_valid at edge k is captured into vd[0] at edge k, counts only if it arrives at the MISR in RUN.
- in_valid high at edge t -> av high after edge t+LATENCY-1. MISR samples N22/N23 at edge t+LATENCY. This matches a c17 output registered LATENCY times.
- Throughput: one response per cycle. Back-to-back in_valid is allowed.
- Final update edge:
  - done=1 and busy=0 after that edge.
  - pass valid in the same cycle.
- start coincident with the final update edge: final update completes and state goes DONE. start is not re-sampled.
- vec_cnt never exceeds NVEC.

## Configuration
- C17_MISR_XCHK_EN defined:
  - Simulation-only check on every cycle with state RUN and av=1.
  - If N22 or N23 is X/Z, issue $error with time and vec_cnt.
  - The update still proceeds.
- Undefined: no check is compiled. Synthesised logic is identical either way.

## Test plan
- Reset: rst=1 for 2 cycles -> busy=0, done=0, pass=0, signature=16'hFFFF, vec_cnt=0.
- NVEC=2, LATENCY=2, N22=N23=0, exp_sig=16'hCF9F:
  - Stimulus: start, then in_valid for 2 consecutive cycles.
  - Signature after edge 1: 16'hEFDF. After edge 2: 16'hCF9F.
  - done=1, pass=1 exactly 2 edges after the second in_valid edge.
- Same run with exp_sig=16'h0000 -> done=1, pass=0.
- Alignment, LATENCY=2, NVEC=1:
  - in_valid at edge t with N23=1, N22=1 only during cycle t+2 -> final signature 16'hEFDC.
  - Moving the 1s to cycle t+1 -> 16'hEFDF.
- Gaps: in_valid pattern 1,0,0,1 with NVEC=2 -> vec_cnt goes 0,1,1,1,2; done rises only after the second aligned update.
- Abort and restart:
  - rst asserted mid-run at vec_cnt=5 -> reset values.
  - A subsequent start plus 16 vectors completes normally with vec_cnt=16.
  - start during RUN is ignored and vec_cnt continues.
